// File: rtl/uart_rx_inter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_inter
//  Description : UART RX byte FIFO shared by NUM_CPUS cores through
//                round-robin arbitrated single-beat AXI read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_inter #(
    parameter int          NUM_CPUS       = 2,
    parameter int          FIFO_DEPTH     = 64,
    parameter logic [31:0] RX_DATA_ADDR   = 32'h6000_1100,
    parameter logic [31:0] RX_STATUS_ADDR = 32'h6000_1104
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      o_Rx_DV,
    input  logic [7:0]                o_Rx_Byte,
    input  logic [NUM_CPUS-1:0]       s_arvalid,
    input  logic [NUM_CPUS-1:0][31:0] s_araddr,
    output logic [NUM_CPUS-1:0]       s_arready,
    output logic [NUM_CPUS-1:0]       s_rvalid,
    output logic [NUM_CPUS-1:0][31:0] s_rdata,
    input  logic [NUM_CPUS-1:0]       s_rready,
    output logic                      rx_irq
);

    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;
    localparam int c_aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_gw = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(FIFO_DEPTH);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_resp = 1'b1;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_cw-1:0] r_count, w_count_next;
    logic            r_overrun, r_irq;
    logic [0:0]      r_state;
    logic [c_gw-1:0] r_last_grant, r_owner, w_win;
    logic [31:0]     r_rdata, w_addr, w_status, w_resp;
    logic            w_any, w_accept, w_pop, w_push, w_is_data, w_is_status;

    // Round-robin scan starting just after the previous winner
    always_comb begin
        int idx;
        w_any = 1'b0;
        w_win = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_CPUS; k++) begin
            idx = int'(r_last_grant) + k;
            if (idx >= NUM_CPUS) idx = idx - NUM_CPUS;
            if (!w_any && s_arvalid[c_gw'(idx)]) begin
                w_any = 1'b1;
                w_win = c_gw'(idx);
            end
        end
    end

    assign w_accept    = !rst && (r_state == c_st_idle) && w_any;
    assign w_addr      = s_araddr[w_win];
    assign w_is_data   = (w_addr == RX_DATA_ADDR);
    assign w_is_status = (w_addr == RX_STATUS_ADDR);
    assign w_pop       = w_accept && w_is_data && (r_count != '0);
    assign w_push      = o_Rx_DV && ((r_count < c_depth) || w_pop);

    always_comb begin
        s_arready = '0;
        if (w_accept) s_arready[w_win] = 1'b1;
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)      w_count_next = r_count + c_cw'(1);
        else if (w_pop && !w_push) w_count_next = r_count - c_cw'(1);
    end

    always_comb begin
        w_status              = '0;
        w_status[0]           = (r_count != '0);
        w_status[1]           = (r_count == c_depth);
        w_status[2]           = r_overrun;
        w_status[15+c_cw:16]  = r_count;
    end

    always_comb begin
        w_resp = '0;
        if (w_is_data && (r_count != '0)) w_resp = {23'b0, 1'b1, r_mem[r_rd_ptr]};
        else if (w_is_status)             w_resp = w_status;
    end

    // Storage carries no reset; occupancy is governed by the pointers
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= o_Rx_Byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_owner      <= '0;
            r_last_grant <= c_gw'(NUM_CPUS - 1);
            r_rdata      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overrun    <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            r_count <= w_count_next;
            r_irq   <= (w_count_next != '0);

            // A dropped byte outranks the clear from a status read
            if (o_Rx_DV && !w_push)           r_overrun <= 1'b1;
            else if (w_accept && w_is_status) r_overrun <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_owner      <= w_win;
                        r_last_grant <= w_win;
                        r_rdata      <= w_resp;
                        r_state      <= c_st_resp;
                    end
                end
                default: begin
                    if (s_rready[r_owner]) r_state <= c_st_idle;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CPUS; i++) begin : g_port
        assign s_rvalid[i] = (r_state == c_st_resp) && (r_owner == c_gw'(i));
        assign s_rdata[i]  = s_rvalid[i] ? r_rdata : 32'h0;
    end

    assign rx_irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_inter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_inter
//  Description : Self-checking bench for uart_rx_inter against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_inter;

    localparam int          NCPU   = 2;
    localparam int          DEPTH  = 64;
    localparam logic [31:0] A_DATA = 32'h6000_1100;
    localparam logic [31:0] A_STAT = 32'h6000_1104;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  o_Rx_DV;
    logic [7:0]            o_Rx_Byte;
    logic [NCPU-1:0]       s_arvalid;
    logic [NCPU-1:0][31:0] s_araddr;
    logic [NCPU-1:0]       s_arready;
    logic [NCPU-1:0]       s_rvalid;
    logic [NCPU-1:0][31:0] s_rdata;
    logic [NCPU-1:0]       s_rready;
    logic                  rx_irq;

    always #5 clk = ~clk;

    uart_rx_inter #(
        .NUM_CPUS(NCPU), .FIFO_DEPTH(DEPTH),
        .RX_DATA_ADDR(A_DATA), .RX_STATUS_ADDR(A_STAT)
    ) dut (
        .clk(clk), .rst(rst), .o_Rx_DV(o_Rx_DV), .o_Rx_Byte(o_Rx_Byte),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rready(s_rready),
        .rx_irq(rx_irq)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] q[$];
    bit         m_ovr;
    int         m_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(q.size()) * 65536;
        if (m_ovr)           s = s + 4;
        if (q.size() == DEPTH) s = s + 2;
        if (q.size() != 0)   s = s + 1;
        return s;
    endfunction

    function automatic void m_push(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    function automatic void m_reset();
        q.delete();
        m_ovr  = 1'b0;
        m_last = NCPU - 1;
    endfunction

    // All tasks start and end 1 time unit after a rising edge
    task automatic push_byte(input logic [7:0] b);
        o_Rx_DV = 1'b1; o_Rx_Byte = b;
        @(posedge clk); #1;
        o_Rx_DV = 1'b0;
        m_push(b);
    endtask

    task automatic do_read(input int core, input logic [31:0] addr, input int stall,
                           input bit push_now, input logic [7:0] pb);
        logic [31:0] exp;
        int          waitc;
        s_arvalid[core] = 1'b1;
        s_araddr[core]  = addr;
        #1;
        waitc = 0;
        while (!s_arready[core] && waitc < 20) begin
            @(posedge clk); #2;
            waitc++;
        end
        check("arready", 32'(s_arready), 32'(1 << core));
        if (addr == A_DATA && q.size() != 0) exp = 32'h100 | 32'(q.pop_front());
        else if (addr == A_STAT) begin exp = m_status(); m_ovr = 1'b0; end
        else exp = 32'h0;
        if (push_now) begin
            o_Rx_DV = 1'b1; o_Rx_Byte = pb;
            m_push(pb);
        end
        m_last = core;
        @(posedge clk); #1;
        s_arvalid[core] = 1'b0;
        o_Rx_DV = 1'b0;
        check("rvalid", 32'(s_rvalid), 32'(1 << core));
        check("rdata", s_rdata[core], exp);
        check("rdata_other", s_rdata[1-core], 32'h0);
        check("rx_irq", 32'(rx_irq), 32'(q.size() != 0));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("rvalid_hold", 32'(s_rvalid), 32'(1 << core));
            check("rdata_hold", s_rdata[core], exp);
        end
        s_rready[core] = 1'b1;
        @(posedge clk); #1;
        s_rready[core] = 1'b0;
        check("rvalid_drop", 32'(s_rvalid), 32'h0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
    endtask

    initial begin
        logic [31:0] exp;
        int          w;
        rst = 1'b1; o_Rx_DV = 1'b0; o_Rx_Byte = '0;
        s_arvalid = '0; s_araddr = '0; s_rready = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_arready", 32'(s_arready), 32'h0);
        check("rst_rvalid", 32'(s_rvalid), 32'h0);
        check("rst_rdata0", s_rdata[0], 32'h0);
        check("rst_rdata1", s_rdata[1], 32'h0);
        check("rst_irq", 32'(rx_irq), 32'h0);
        rst = 1'b0;
        do_read(0, A_STAT, 0, 0, 8'h0);

        // Single byte, then empty read from core 1
        push_byte(8'h41);
        check("irq_rise", 32'(rx_irq), 32'h1);
        do_read(0, A_DATA, 0, 0, 8'h0);
        do_read(1, A_DATA, 0, 0, 8'h0);
        do_read(1, A_STAT, 0, 0, 8'h0);

        // Overrun: 65 pushes into a 64-entry FIFO
        for (int i = 0; i <= 64; i++) push_byte(8'(i));
        do_read(0, A_STAT, 0, 0, 8'h0);
        do_read(1, A_STAT, 0, 0, 8'h0);
        for (int i = 0; i < 64; i++) do_read(i % 2, A_DATA, 0, 0, 8'h0);
        do_read(0, A_DATA, 0, 0, 8'h0);

        // Full FIFO with push in the data-read accept cycle
        for (int i = 0; i < 64; i++) push_byte(8'(8'h80 + i));
        do_read(0, A_DATA, 0, 1, 8'hAB);
        do_read(1, A_STAT, 0, 0, 8'h0);
        do_read(0, 32'h6000_1108, 1, 0, 8'h0);

        // Contention: both cores hold arvalid on the data register
        pulse_reset();
        push_byte(8'h10); push_byte(8'h11); push_byte(8'h12);
        s_arvalid = '1;
        s_araddr[0] = A_DATA; s_araddr[1] = A_DATA;
        for (int g = 0; g < 3; g++) begin
            #1;
            w = (m_last + 1) % NCPU;
            check("arb_grant", 32'(s_arready), 32'(1 << w));
            exp = 32'h100 | 32'(q.pop_front());
            m_last = w;
            @(posedge clk); #1;
            check("arb_rvalid", 32'(s_rvalid), 32'(1 << w));
            check("arb_rdata", s_rdata[w], exp);
            for (int s = 0; s < 3; s++) begin
                @(posedge clk); #1;
                check("arb_hold_rvalid", 32'(s_rvalid), 32'(1 << w));
                check("arb_hold_rdata", s_rdata[w], exp);
                check("arb_hold_arready", 32'(s_arready), 32'h0);
            end
            s_rready[w] = 1'b1;
            @(posedge clk); #1;
            s_rready[w] = 1'b0;
        end
        s_arvalid = '0;
        check("arb_empty_irq", 32'(rx_irq), 32'h0);

        // Reset while a response is pending
        push_byte(8'h55); push_byte(8'h66);
        s_arvalid[0] = 1'b1; s_araddr[0] = A_DATA;
        @(posedge clk); #1;
        s_arvalid[0] = 1'b0;
        check("pre_rst_rvalid", 32'(s_rvalid), 32'h1);
        rst = 1'b1;
        #1;
        check("async_rst_rvalid", 32'(s_rvalid), 32'h0);
        check("async_rst_rdata", s_rdata[0], 32'h0);
        check("async_rst_irq", 32'(rx_irq), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        do_read(1, A_STAT, 0, 0, 8'h0);

        // Randomized traffic against the queue model
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 3))
                0, 1: push_byte(8'($urandom));
                2: do_read($urandom_range(0, 1), A_DATA, $urandom_range(0, 2),
                           bit'($urandom_range(0, 1)), 8'($urandom));
                default: do_read($urandom_range(0, 1),
                                 ($urandom_range(0, 3) == 0) ? $urandom : A_STAT,
                                 $urandom_range(0, 2), bit'($urandom_range(0, 1)),
                                 8'($urandom));
            endcase
        end
        do_read(0, A_STAT, 0, 0, 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_inter.md
# uart_rx_inter

Receive-side companion to the core-facing UART transmit path. Bytes from the UART receiver are buffered in a shared byte FIFO. Any of the `NUM_CPUS` cores can read them through a single-beat AXI read channel: a data register and a status register, with round-robin arbitration between cores. The block sits between the UART RX serializer and the per-core AXI read ports in the 0x6000_1xxx peripheral window.

## Interface
Parameters:
- `NUM_CPUS`, 2: number of core read ports.
- `FIFO_DEPTH`, 64: RX byte FIFO entries. Must be a power of 2, ≤ 32768.
- `RX_DATA_ADDR`, 32'h6000_1100: pop-one-byte register.
- `RX_STATUS_ADDR`, 32'h6000_1104: status register.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `o_Rx_DV`, in, 1: one-cycle strobe from the UART receiver; byte is valid.
- `o_Rx_Byte`, in, 8: received byte, qualified by `o_Rx_DV`.
- `s_arvalid`, in, `NUM_CPUS`: per-core read-address valid.
- `s_araddr`, in, `[NUM_CPUS-1:0][31:0]`: per-core read address.
- `s_arready`, out, `NUM_CPUS`: per-core address accept.
- `s_rvalid`, out, `NUM_CPUS`: per-core read-data valid.
- `s_rdata`, out, `[NUM_CPUS-1:0][31:0]`: per-core read data.
- `s_rready`, in, `NUM_CPUS`: per-core read-data accept.
- `rx_irq`, out, 1: level signal; FIFO is non-empty.

## Operation
FIFO:
- Count width is `CW = $clog2(FIFO_DEPTH)+1`.
- Push when `o_Rx_DV && (count < FIFO_DEPTH || pop_this_cycle)`.
- Push while full with no pop drops the byte and sets sticky `overrun`.
- A simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.

Read FSM, states IDLE and RESP:
- **IDLE:**
  - The arbiter scans cores starting at `last_grant+1` (mod `NUM_CPUS`). The first core with `s_arvalid` high wins.
  - `s_arready[win]` is asserted combinationally in the same cycle; all other `s_arready` bits are 0.
  - On the handshake: capture the winner index, compute the response word into a register, apply any side effect, update `last_grant`, then go to RESP.
- **RESP:**
  - `s_rvalid[owner]=1` with the registered `s_rdata[owner]`. All `s_arready`=0.
  - On `s_rready[owner]`, go to IDLE in the next cycle.
  - Other cores' `s_rdata` and `s_rvalid` are 0.

Response word, decoded from the captured address:
- **`RX_DATA_ADDR`:**
  - If the FIFO is non-empty: `{23'b0, 1'b1, head_byte}` and pop one entry.
  - If empty: `32'h0` and no pop.
- **`RX_STATUS_ADDR`:**
  - bit0 = non-empty, bit1 = full, bit2 = overrun.
  - bits `[15+CW:16]` = count; all other bits 0.
  - The read clears `overrun`. If an overrun occurs in the same cycle, set wins.
- **Any other address:** `32'h0`, no side effect.

Other rules:
- `rx_irq` = (count != 0), registered from count.

## Timing
Reset values:
- All `s_arready`, `s_rvalid`, `s_rdata`, and `rx_irq` are 0.
- FSM = IDLE, count = 0, pointers = 0, `overrun` = 0.
- `last_grant = NUM_CPUS-1`, so core 0 has first priority.

Latency and handshake:
- Address accepted in cycle T → `s_rvalid` asserted at T+1.
- Minimum of 2 cycles per read; one outstanding read in total.
- `s_rvalid` and `s_rdata` hold stable until `s_rready` is seen.
- The data register samples head and count at the accept edge.
- A byte pushed in the accept cycle is not visible to that read.
- The pop takes effect at the accept edge. Count and `rx_irq` reflect it at T+1.

Reset and arbitration:
- Reset mid-RESP drops `s_rvalid` immediately (asynchronous). The pending response is lost and FIFO contents are cleared.
- The arbiter only moves in IDLE. A core holding `s_arvalid` is not starved: with all cores requesting, grants alternate.

## Test plan
- **Single byte:** after reset, `o_Rx_DV` with byte 0x41; core 0 reads `RX_DATA_ADDR` → `s_rdata[0]=32'h0000_0141` at T+1, count 0, `rx_irq` falls.
- **Empty read:** core 1 reads `RX_DATA_ADDR` with the FIFO empty → `32'h0`, count stays 0.
- **Overrun:** push 65 bytes (0x00..0x40) with no reads.
  - Status read → bits0/1/2 = 1, count field = 64 (`32'h0040_0007`).
  - A second status read → `32'h0040_0003`.
  - Data reads return 0x00..0x3F in order; 0x40 was dropped.
- **Contention:** both cores hold `s_arvalid` on `RX_DATA_ADDR` with bytes 0x10, 0x11, 0x12 queued.
  - Grants go core0, core1, core0; they receive 0x110, 0x111, 0x112.
  - Each `s_rvalid` is held until its `s_rready`, including with 3 stall cycles.
- **Full with simultaneous push/pop:** FIFO full, `o_Rx_DV` in the data-read accept cycle → new byte accepted, count stays 64, `overrun` stays 0.
- **Reset mid-operation:** assert `rst` in RESP → `s_rvalid` falls the same cycle, count 0. After release, status read returns `32'h0`.
